// File: rtl/arch_reg_dump_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// arch_reg_dump_if: valid/ready beat stream carrying dumped register values.
// Rev 1.0
// -----------------------------------------------------------------------------
interface arch_reg_dump_if #(
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [5:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface
`default_nettype wire

// File: rtl/arch_reg_dump.sv
`default_nettype none
// -----------------------------------------------------------------------------
// arch_reg_dump: waits for core quiescence, then streams every architectural
// register out. REG_DUMP_CHECKSUM_EN appends an XOR checksum beat. Rev 1.0
// -----------------------------------------------------------------------------
module arch_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 1024
) (
  input  wire                clk,
  input  wire                reset,
  input  wire                start,
  input  wire                quiescent,
  output logic [4:0]         rf_addr,
  input  wire  [DATA_W-1:0]  rf_data,
  arch_reg_dump_if.master    dump,
  output logic               busy,
  output logic               timeout_err
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]       LAST_PTR = 5'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_Q = 3'd1,
    S_LOAD   = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic             handshake;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_acc;
  logic              csum_phase;
`endif

  assign rf_addr   = ptr;
  assign busy      = (state != S_IDLE);
  assign handshake = dump.dump_valid && dump.dump_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WAIT_Q;
        end
      end
      S_WAIT_Q: begin
        if (quiescent) begin
          state_nxt = S_LOAD;
        end else if (wait_cnt == CNT_MAX) begin
          state_nxt = S_DONE;
        end
      end
      S_LOAD: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          state_nxt = dump.dump_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= 5'd0;
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_idx   <= 6'd0;
      dump.dump_data  <= '0;
      dump.dump_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_acc        <= '0;
      csum_phase      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            ptr         <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_acc    <= '0;
            csum_phase  <= 1'b0;
`endif
          end
        end
        S_WAIT_Q: begin
          if (!quiescent) begin
            if (wait_cnt == CNT_MAX) begin
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          dump.dump_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          // The trailing beat reuses LOAD; the accumulator is already final here.
          if (csum_phase) begin
            dump.dump_idx  <= 6'd32;
            dump.dump_data <= csum_acc;
            dump.dump_last <= 1'b1;
          end else begin
            dump.dump_idx  <= {1'b0, ptr};
            dump.dump_data <= rf_data;
            dump.dump_last <= 1'b0;
          end
`else
          dump.dump_idx  <= {1'b0, ptr};
          dump.dump_data <= rf_data;
          dump.dump_last <= (ptr == LAST_PTR);
`endif
        end
        S_SEND: begin
          if (handshake) begin
            dump.dump_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_acc <= csum_acc ^ dump.dump_data;
            if (!dump.dump_last) begin
              if (ptr == LAST_PTR) begin
                csum_phase <= 1'b1;
              end else begin
                ptr <= ptr + 5'd1;
              end
            end
`else
            if (!dump.dump_last) begin
              ptr <= ptr + 5'd1;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arch_reg_dump.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_arch_reg_dump: directed bench for arch_reg_dump with a register-file model.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_arch_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NBEATS = 33;
`else
  localparam int NBEATS = 32;
`endif
  localparam logic [31:0] CSUM = 32'hFFFF_F81D;

  logic        clk;
  logic        reset;
  logic        start;
  logic        quiescent;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        busy;
  logic        timeout_err;
  logic [31:0] rf [32];

  int vectors;
  int miscompares;

  arch_reg_dump_if #(.DATA_W(32)) dif ();

  arch_reg_dump #(
    .NUM_REGS (32),
    .DATA_W   (32),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .quiescent   (quiescent),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .dump        (dif),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  assign rf_data = rf[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_data(input int n);
    case (n)
      1:       return 32'h0000_07FF;
      2:       return 32'hFFFF_FFFF;
      31:      return 32'h0000_0001;
      32:      return CSUM;
      default: return 32'(n);
    endcase
  endfunction

  // Accepts a whole dump, optionally stalling one beat for stall_len cycles.
  task automatic collect(input int stall_idx, input int stall_len);
    int          n;
    int          stalled;
    int          guard;
    bit          done;
    logic [5:0]  hold_idx;
    logic [31:0] hold_data;
    n = 0; stalled = 0; guard = 0; done = 1'b0;
    hold_idx = '0; hold_data = '0;
    while (!done && guard < 400) begin
      guard++;
      if (dif.dump_valid) begin
        if (int'(dif.dump_idx) == stall_idx && stalled < stall_len) begin
          if (stalled == 0) begin
            hold_idx  = dif.dump_idx;
            hold_data = dif.dump_data;
          end else begin
            check("stall_idx", 32'(dif.dump_idx), 32'(hold_idx));
            check("stall_data", dif.dump_data, hold_data);
          end
          dif.dump_ready = 1'b0;
          stalled++;
        end else begin
          dif.dump_ready = 1'b1;
          check("beat_idx", 32'(dif.dump_idx), 32'(n));
          check("beat_data", dif.dump_data, exp_data(n));
          check("beat_last", 32'(dif.dump_last), 32'(n == NBEATS - 1));
          n++;
          if (dif.dump_last) done = 1'b1;
        end
      end else begin
        dif.dump_ready = 1'b1;
      end
      step();
    end
    check("dump_done", 32'(done), 32'd1);
    check("beat_count", 32'(n), 32'(NBEATS));
    check("stall_cycles", 32'(stalled), 32'(stall_len));
    check("busy_after_last", 32'(busy), 32'd1);
    step();
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  saw_valid;
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rf[1] = 32'd2047; rf[2] = 32'hFFFF_FFFF; rf[31] = 32'd1;
    reset = 1'b1; start = 1'b0; quiescent = 1'b1; dif.dump_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    check("rst_valid", 32'(dif.dump_valid), 32'd0);
    check("rst_idx", 32'(dif.dump_idx), 32'd0);
    check("rst_data", dif.dump_data, 32'd0);
    check("rst_last", 32'(dif.dump_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd0);

    // Full dump, sink always ready
    pulse_start();
    collect(-1, 0);

    // Backpressure on the idx5 beat
    pulse_start();
    collect(5, 5);

    // Delayed quiescence: first beat on the 12th cycle after start
    quiescent = 1'b0;
    pulse_start();
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cyc++;
    end
    quiescent = 1'b1;
    while (!dif.dump_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("q_latency", 32'(cyc), 32'd12);
    check("q_terr", 32'(timeout_err), 32'd0);
    collect(-1, 0);

    // Quiescence timeout
    quiescent = 1'b0;
    pulse_start();
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dif.dump_valid) saw_valid = 1'b1;
    end
    check("to_early", 32'(timeout_err), 32'd0);
    step();
    if (dif.dump_valid) saw_valid = 1'b1;
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_busy_done", 32'(busy), 32'd1);
    step();
    check("to_idle", 32'(busy), 32'd0);
    check("to_sticky", 32'(timeout_err), 32'd1);
    check("to_no_valid", 32'(saw_valid), 32'd0);
    quiescent = 1'b1;
    pulse_start();
    check("to_cleared", 32'(timeout_err), 32'd0);
    collect(-1, 0);

    // Reset during the idx10 beat
    pulse_start();
    dif.dump_ready = 1'b1;
    cyc = 0;
    while (!(dif.dump_valid && dif.dump_idx == 6'd10) && cyc < 100) begin
      step();
      cyc++;
    end
    check("reach_idx10", 32'(dif.dump_idx), 32'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_valid", 32'(dif.dump_valid), 32'd0);
    check("mid_idx", 32'(dif.dump_idx), 32'd0);
    check("mid_data", dif.dump_data, 32'd0);
    check("mid_last", 32'(dif.dump_last), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_addr", 32'(rf_addr), 32'd0);
    pulse_start();
    collect(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arch_reg_dump.md
Name: arch_reg_dump

Overview:
- Hardware producer of architectural register state; the reverse direction of the bench checkers that peek into the register file by hierarchy.
- On a start request, waits until the core is quiescent (ROB empty, no stores in flight), then walks the architectural register file and streams every register out over a valid/ready interface.
- Sits beside the architectural register file in core.
- Used by benches and by the FPGA debug path for end-of-program state extraction.

Parameters:
- NUM_REGS, 32: architectural registers to dump (indices 0..NUM_REGS-1).
- DATA_W, 32: register width.
- TIMEOUT, 1024: maximum cycles to wait for quiescence before aborting.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  dump request pulse; sampled only in IDLE.
- quiescent  in  1  high when ROB is empty and no stores are in flight.
- rf_addr  out  5  architectural register file read address; combinational read.
- rf_data  in  DATA_W  register file read data, valid in the same cycle as rf_addr.
- dump_valid  out  1  output beat valid.
- dump_ready  in  1  sink ready.
- dump_idx  out  6  register index of the current beat (32 = checksum beat, see Optional Feature).
- dump_data  out  DATA_W  register value.
- dump_last  out  1  final beat of the dump.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set when the quiescence wait expires; cleared by reset or by the next accepted start.

Behaviour:
- Interface reset: reset is one clock, synchronous and active-high; it is named reset and the clock is named clk.
- Output reset values: state=IDLE; dump_valid=0, dump_idx=0, dump_data=0, dump_last=0, busy=0, timeout_err=0, rf_addr=0; internal wait counter=0.
- States: IDLE, WAIT_Q, LOAD, SEND, DONE.
- IDLE:
  - start=1 -> WAIT_Q; clear timeout_err and the wait counter; set rd pointer=0.
  - start is ignored in every other state.
- WAIT_Q:
  - quiescent=1 -> LOAD.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 with quiescent still 0 -> set timeout_err -> DONE. No beats are emitted.
- LOAD (1 cycle):
  - rf_addr = pointer.
  - Capture rf_data into dump_data and pointer into dump_idx.
  - Set dump_valid=1; set dump_last=(pointer==NUM_REGS-1).
  - -> SEND.
- SEND:
  - Hold dump_valid, dump_idx, dump_data and dump_last stable while dump_ready=0.
  - On dump_valid&&dump_ready: if dump_last -> DONE with dump_valid=0; else pointer++ and -> LOAD with dump_valid=0.
  - Throughput: 1 beat per 2 cycles minimum.
- DONE: one cycle with busy=1 -> IDLE.
- x0 is read from the register file like any other register; no special-casing (the file returns 0).
- dump_ready is ignored when dump_valid=0.
- dump_valid never depends combinationally on dump_ready.
- quiescent deasserting after WAIT_Q has been left does not stop the dump; the caller guarantees the core stays halted.
- Reset mid-dump: everything returns to reset values next cycle and any partially sent stream is abandoned.
- Pointer uses 5 bits for NUM_REGS=32; comparison is against NUM_REGS-1 (no wrap).

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W accumulator, cleared on start, XORs each beat's dump_data at handshake.
  - After register NUM_REGS-1 is accepted (dump_last=0 on that beat), one extra beat is emitted with dump_idx=32, dump_data=accumulator and dump_last=1.
- Undefined:
  - No accumulator.
  - The register NUM_REGS-1 beat carries dump_last=1.
  - dump_idx never exceeds NUM_REGS-1.

Test Plan:
1. Preload RF: x1=2047, x2=0xFFFFFFFF, x31=1, others=idx; quiescent=1, dump_ready=1, pulse start.
   - Required: 32 beats, idx 0..31 in order.
   - Required data: idx1=0x7FF, idx2=0xFFFFFFFF, idx31=1.
   - Required: dump_last only on idx31 (checksum off); busy falls 2 cycles after the last handshake.
2. Hold dump_ready=0 for 5 cycles on the idx5 beat.
   - Required: dump_valid, idx and data are stable for all 5 cycles.
   - Required: idx6 appears only after ready rises; no beat is lost or duplicated.
3. quiescent=0 for 10 cycles after start, then 1.
   - Required: first beat appears on cycle 12 (±1).
   - Required: timeout_err=0.
4. TIMEOUT=16, quiescent held 0.
   - Required: timeout_err=1 after 16 cycles; no dump_valid.
   - Required: state returns to IDLE; the next start clears timeout_err.
5. reset asserted during the idx10 beat.
   - Required: next cycle all outputs=0 and busy=0.
   - Required: a new start re-dumps from idx0.
6. REG_DUMP_CHECKSUM_EN, same RF as test 1.
   - Required: 33rd beat idx=32 with data equal to the XOR of all 32 values.
   - Required: dump_last only on that beat.
